// File: rtl/fpalu_sub_seq_if.sv
// fpalu_sub_seq_if: operand/result handshake bundle for the sequential FP subtractor.
// Latency: none; wiring only.
// Backpressure: valid/ready on both the operand side and the result side.
interface fpalu_sub_seq_if;
    logic [31:0] a_input;
    logic [31:0] b_input;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] diff;
    logic        zero;
    logic        ovf;
    logic        unf;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a_input, b_input, in_valid, out_ready,
        input  in_ready, diff, zero, ovf, unf, out_valid
    );

    modport slave (
        input  a_input, b_input, in_valid, out_ready,
        output in_ready, diff, zero, ovf, unf, out_valid
    );
endinterface

// File: rtl/fpalu_sub_seq.sv
// fpalu_sub_seq: multi-cycle IEEE-754 single subtract (diff = a - b), denormals flushed; FPALU_SUB_RNE_EN adds RNE rounding.
// Latency: out_valid 3+k cycles after accept for k normalise steps (+1 with FPALU_SUB_RNE_EN); specials take 2.
// Backpressure: one op in flight; in_ready only when idle, result held stable while out_ready is low.
module fpalu_sub_seq #(
    parameter int MAX_SHIFT = 27
) (
    input  logic           clock,
    input  logic           reset,
    fpalu_sub_seq_if.slave bus
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0] a_r, b_r;
    logic        spec_r;
    logic [31:0] spec_dat_r;
    logic        sign_r, sub_r;
    logic [9:0]  exp_r;
    logic [26:0] big_r, sml_r;
    logic [27:0] mag_r;
    logic        zero_r, unf_r;

    logic accept;
    assign accept = bus.in_valid && (state == S_IDLE);

    // Capture-time special detection on raw operands (b sign is the raw one here).
    logic [7:0]  in_ea, in_eb;
    logic        in_a_nan, in_b_nan, in_a_inf, in_b_inf, in_special;
    logic [31:0] in_spec_dat;

    always_comb begin
        in_ea       = bus.a_input[30:23];
        in_eb       = bus.b_input[30:23];
        in_a_nan    = (&in_ea) && (|bus.a_input[22:0]);
        in_b_nan    = (&in_eb) && (|bus.b_input[22:0]);
        in_a_inf    = (&in_ea) && !(|bus.a_input[22:0]);
        in_b_inf    = (&in_eb) && !(|bus.b_input[22:0]);
        in_special  = in_a_nan || in_b_nan || in_a_inf || in_b_inf;
        in_spec_dat = QNAN;
        // inf - inf of equal raw sign is the invalid case; opposite signs just give inf
        if (in_a_nan || in_b_nan || (in_a_inf && in_b_inf && (bus.a_input[31] == bus.b_input[31])))
            in_spec_dat = QNAN;
        else if (in_a_inf)
            in_spec_dat = {bus.a_input[31], 8'hFF, 23'd0};
        else
            in_spec_dat = {~bus.b_input[31], 8'hFF, 23'd0};
    end

    // Alignment: order by magnitude, right-shift the smaller with sticky collection.
    logic [7:0]  ea, eb, big_e, sml_e, gap, sh;
    logic [22:0] ma, mb;
    logic        swap, big_s;
    logic [26:0] big_sig, sml_sig, sml_al;
    logic [53:0] sml_wide;

    always_comb begin
        ea       = a_r[30:23];
        eb       = b_r[30:23];
        ma       = (ea == 8'd0) ? 23'd0 : a_r[22:0];
        mb       = (eb == 8'd0) ? 23'd0 : b_r[22:0];
        swap     = {eb, mb} > {ea, ma};
        big_e    = swap ? eb : ea;
        sml_e    = swap ? ea : eb;
        big_s    = swap ? b_r[31] : a_r[31];
        big_sig  = swap ? {eb != 8'd0, mb, 3'b000} : {ea != 8'd0, ma, 3'b000};
        sml_sig  = swap ? {ea != 8'd0, ma, 3'b000} : {eb != 8'd0, mb, 3'b000};
        gap      = big_e - sml_e;
        sh       = (gap > 8'(MAX_SHIFT)) ? 8'(MAX_SHIFT) : gap;
        sml_wide = {sml_sig, 27'd0} >> sh;
        sml_al   = {sml_wide[53:28], sml_wide[27] | (|sml_wide[26:0])};
    end

    // One normalisation step per cycle.
    logic [27:0] norm_mag;
    logic [9:0]  norm_exp;
    logic        norm_zero, norm_unf, norm_exit;

    always_comb begin
        norm_mag  = mag_r;
        norm_exp  = exp_r;
        norm_zero = 1'b0;
        norm_unf  = 1'b0;
        norm_exit = 1'b0;
        if (mag_r[27]) begin
            norm_mag  = {1'b0, mag_r[27:2], mag_r[1] | mag_r[0]};
            norm_exp  = exp_r + 10'd1;
            norm_exit = 1'b1;
        end else if (mag_r == 28'd0) begin
            norm_zero = 1'b1;
            norm_exit = 1'b1;
        end else if (mag_r[26]) begin
            norm_exit = 1'b1;
        end else if (exp_r <= 10'd1) begin
            norm_zero = 1'b1;
            norm_unf  = 1'b1;
            norm_exit = 1'b1;
        end else begin
            norm_mag  = {mag_r[26:0], 1'b0};
            norm_exp  = exp_r - 10'd1;
        end
    end

`ifdef FPALU_SUB_RNE_EN
    logic        rnd_up;
    logic [24:0] rnd_sum;

    always_comb begin
        rnd_up  = mag_r[2] & (mag_r[1] | mag_r[0] | mag_r[3]);
        rnd_sum = {1'b0, mag_r[26:3]} + {24'd0, rnd_up};
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_nxt = S_ALIGN;
            S_ALIGN: state_nxt = spec_r ? S_DONE : S_ADD;
            S_ADD:   state_nxt = S_NORM;
            S_NORM: begin
                if (norm_exit) begin
`ifdef FPALU_SUB_RNE_EN
                    state_nxt = S_ROUND;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_ROUND: state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            spec_r     <= 1'b0;
            spec_dat_r <= 32'd0;
            sign_r     <= 1'b0;
            sub_r      <= 1'b0;
            exp_r      <= 10'd0;
            big_r      <= 27'd0;
            sml_r      <= 27'd0;
            mag_r      <= 28'd0;
            zero_r     <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_r        <= bus.a_input;
                        b_r        <= {~bus.b_input[31], bus.b_input[30:0]};
                        spec_r     <= in_special;
                        spec_dat_r <= in_spec_dat;
                        zero_r     <= 1'b0;
                        unf_r      <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    sign_r <= big_s;
                    sub_r  <= a_r[31] ^ b_r[31];
                    exp_r  <= {2'b00, big_e};
                    big_r  <= big_sig;
                    sml_r  <= sml_al;
                end
                S_ADD: begin
                    // big >= small by construction, so the subtract never goes negative
                    mag_r <= sub_r ? ({1'b0, big_r} - {1'b0, sml_r})
                                   : ({1'b0, big_r} + {1'b0, sml_r});
                end
                S_NORM: begin
                    mag_r  <= norm_mag;
                    exp_r  <= norm_exp;
                    zero_r <= norm_zero;
                    unf_r  <= norm_unf;
                end
`ifdef FPALU_SUB_RNE_EN
                S_ROUND: begin
                    if (rnd_sum[24]) begin
                        mag_r <= {1'b0, 24'h80_0000, 3'b000};
                        exp_r <= exp_r + 10'd1;
                    end else begin
                        mag_r <= {1'b0, rnd_sum[23:0], 3'b000};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    logic [31:0] res_dat;
    logic        res_zero, res_ovf, res_unf;

    always_comb begin
        res_dat  = 32'd0;
        res_zero = 1'b0;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        if (spec_r) begin
            res_dat = spec_dat_r;
        end else if (zero_r) begin
            res_zero = 1'b1;
            res_unf  = unf_r;
        end else if (exp_r >= 10'd255) begin
            res_dat = {sign_r, 8'hFF, 23'd0};
            res_ovf = 1'b1;
        end else begin
            res_dat = {sign_r, exp_r[7:0], mag_r[25:3]};
        end
    end

    // Datapath registers are frozen in DONE, so the decoded result stays stable under backpressure.
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.diff      = bus.out_valid ? res_dat  : 32'd0;
    assign bus.zero      = bus.out_valid & res_zero;
    assign bus.ovf       = bus.out_valid & res_ovf;
    assign bus.unf       = bus.out_valid & res_unf;

endmodule
